// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter (fetch vs load/store), MEM priority with IF anti-starvation.
// Optional ARB_PERF_CNT_EN adds per-requester grant counters.
module sram_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [3:0]        mem_sel,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ack,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              sram_ce,
   output logic              sram_we,
   output logic [3:0]        sram_sel,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic [31:0]       perf_if_cnt,
   output logic [31:0]       perf_mem_cnt
);

   typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   state_t     state;
   logic       owner;
   logic       r_we;
   logic [3:0] starve_cnt;
   logic       grant_mem;
   logic       grant_if;

   always_comb begin
      grant_mem = mem_req && (!if_req || starve_cnt < SMAX);
      grant_if  = if_req && !grant_mem;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         r_we       <= 1'b0;
         starve_cnt <= '0;
         sram_ce    <= 1'b0;
         sram_we    <= 1'b0;
         sram_sel   <= '0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         if_ack     <= 1'b0;
         mem_ack    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_mem || grant_if) begin
                  state      <= ACC;
                  owner      <= grant_mem;
                  r_we       <= grant_mem & mem_we;
                  sram_ce    <= 1'b1;
                  sram_we    <= grant_mem & mem_we;
                  sram_sel   <= grant_mem ? mem_sel : 4'hF;
                  sram_addr  <= grant_mem ? mem_addr : if_addr;
                  sram_wdata <= grant_mem ? mem_wdata : '0;
               end
               // IF progress resets the starvation window
               if (!if_req || grant_if)
                  starve_cnt <= '0;
               else if (grant_mem && starve_cnt < SMAX)
                  starve_cnt <= starve_cnt + 4'd1;
            end
            ACC: begin
               state      <= RESP;
               sram_ce    <= 1'b0;
               sram_we    <= 1'b0;
               sram_sel   <= '0;
               sram_addr  <= '0;
               sram_wdata <= '0;
               if_ack     <= !owner;
               mem_ack    <= owner;
            end
            RESP: begin
               state   <= IDLE;
               if_ack  <= 1'b0;
               mem_ack <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // SRAM data arrives the cycle after the strobe, i.e. during RESP
   assign if_rdata  = (state == RESP && !owner) ? sram_rdata : '0;
   assign mem_rdata = (state == RESP && owner && !r_we) ? sram_rdata : '0;

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_if_cnt  <= '0;
         perf_mem_cnt <= '0;
      end else if (state == IDLE) begin
         if (grant_if)
            perf_if_cnt <= perf_if_cnt + 32'd1;
         if (grant_mem)
            perf_mem_cnt <= perf_mem_cnt + 32'd1;
      end
   end
`else
   assign perf_if_cnt  = '0;
   assign perf_mem_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter.
// Drives after posedge+1, samples at posedge+1; SRAM modelled in-bench.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        sram_ce;
   logic        sram_we;
   logic [3:0]  sram_sel;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata = '0;
   logic [31:0] perf_if_cnt;
   logic [31:0] perf_mem_cnt;

   logic [31:0] ram [256];

   int total = 0;
   int passed = 0;

   sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .if_ack(if_ack), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .sram_ce(sram_ce), .sram_we(sram_we), .sram_sel(sram_sel),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata),
      .perf_if_cnt(perf_if_cnt), .perf_mem_cnt(perf_mem_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_sel[b])
                  ram[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= ram[sram_addr[7:0]];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got === exp)
         passed++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input string tag, input bit m, input bit we,
                       input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd);
      if (m) begin
         mem_req = 1'b1; mem_we = we; mem_sel = sel;
         mem_addr = a; mem_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = a;
      end
      tick;
      check({tag, "_ce"}, sram_ce, 1);
      check({tag, "_addr"}, sram_addr, a);
      check({tag, "_we"}, sram_we, m & we);
      check({tag, "_sel"}, sram_sel, m ? sel : 4'hF);
      tick;
      check({tag, "_ack"}, m ? mem_ack : if_ack, 1);
      check({tag, "_xack"}, m ? if_ack : mem_ack, 0);
      rd = m ? mem_rdata : if_rdata;
      if_req = 1'b0;
      mem_req = 1'b0;
      tick;
      check({tag, "_idle"}, {sram_ce, if_ack, mem_ack}, 0);
   endtask

   initial begin
      logic [31:0] rd;
      bit          order [6];
      bit          exp_if [6];
      int          n;
      int          acks;
      int          exp_ifc;
      int          exp_memc;

      exp_if = '{0, 0, 0, 0, 1, 0};
      for (int i = 0; i < 256; i++) ram[i] = '0;
      ram[8'h10] = 32'hDEADBEEF;
      ram[8'h20] = 32'hFFFFFFFF;
      rst = 1'b0;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0;
      mem_addr = '0; mem_wdata = '0;
      tick; tick;
      check("rst_sram", {sram_ce, sram_we, sram_sel, sram_addr}, 0);
      check("rst_ack", {if_ack, mem_ack, if_rdata, mem_rdata}, 0);
      check("rst_perf", {perf_if_cnt, perf_mem_cnt}, 0);
      rst = 1'b1;
      tick;

      xfer("fetch", 0, 0, 4'h0, 32'h10, 32'h0, rd);
      check("fetch_data", rd, 32'hDEADBEEF);
      xfer("store", 1, 1, 4'b0011, 32'h20, 32'h12345678, rd);
      check("store_rdata0", rd, 0);
      xfer("load", 1, 0, 4'hF, 32'h20, 32'h0, rd);
      check("load_data", rd, 32'hFFFF5678);

      // contention: both held high, MEM stores to 0x40
      mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'h3;
      mem_addr = 32'h40; mem_wdata = 32'h0000AAAA;
      if_req = 1'b1; if_addr = 32'h10;
      n = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         tick;
         if (sram_ce && sram_addr == 32'h10)
            check("cont_if_wesel", {sram_we, sram_sel}, 5'h0F);
         if (mem_ack || if_ack) begin
            order[n] = if_ack;
            n++;
         end
      end
      if_req = 1'b0; mem_req = 1'b0;
      check("cont_count", n, 6);
      for (int i = 0; i < 6; i++)
         check($sformatf("cont_order%0d", i), order[i], exp_if[i]);
      tick; tick;

      // async reset mid-ACC
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h10;
      tick;
      check("arst_ce_before", sram_ce, 1);
      #2 rst = 1'b0;
      #1;
      check("arst_ce", sram_ce, 0);
      check("arst_ack", {if_ack, mem_ack}, 0);
      check("arst_perf", {perf_if_cnt, perf_mem_cnt}, 0);
      mem_req = 1'b0;
      #3 rst = 1'b1;
      acks = 0;
      for (int c = 0; c < 5; c++) begin
         tick;
         if (mem_ack || if_ack || sram_ce) acks++;
      end
      check("arst_no_ack", acks, 0);

      // one-cycle request pulse still completes the store
      mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF;
      mem_addr = 32'h30; mem_wdata = 32'hA5A5A5A5;
      tick;
      mem_req = 1'b0; mem_wdata = 32'h11111111;
      check("drop_ce", sram_ce, 1);
      check("drop_wdata", sram_wdata, 32'hA5A5A5A5);
      tick;
      check("drop_ack", mem_ack, 1);
      tick;
      check("drop_ram", ram[8'h30], 32'hA5A5A5A5);

      xfer("sel0", 1, 1, 4'h0, 32'h10, 32'h0, rd);
      check("sel0_ram", ram[8'h10], 32'hDEADBEEF);

      xfer("f1", 0, 0, 4'h0, 32'h10, 32'h0, rd);
      check("f1_data", rd, 32'hDEADBEEF);
      xfer("f2", 0, 0, 4'h0, 32'h20, 32'h0, rd);
      check("f2_data", rd, 32'hFFFF5678);
      xfer("f3", 0, 0, 4'h0, 32'h30, 32'h0, rd);
      check("f3_data", rd, 32'hA5A5A5A5);

`ifdef ARB_PERF_CNT_EN
      exp_ifc = 3; exp_memc = 2;
`else
      exp_ifc = 0; exp_memc = 0;
`endif
      check("perf_if", perf_if_cnt, 32'(exp_ifc));
      check("perf_mem", perf_mem_cnt, 32'(exp_memc));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
